// File: rtl/waveform_sequencer.sv
// Waveform sequencer: steps a sample-memory address window on each waveform clock rising edge
// and forwards the returned samples to the DAC interface with a valid strobe.
module waveform_sequencer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  sys_clk_i,
    input  logic                  sys_rst_i,
    input  logic                  ws_en_i,
    input  logic                  ws_mode_i,
    input  logic                  ws_wc_clk_i,
    input  logic [ADDR_WIDTH-1:0] ws_start_addr_i,
    input  logic [ADDR_WIDTH-1:0] ws_end_addr_i,
    output logic                  ws_mem_rd_o,
    output logic [ADDR_WIDTH-1:0] ws_mem_addr_o,
    input  logic [DATA_WIDTH-1:0] ws_mem_data_i,
    output logic [DATA_WIDTH-1:0] ws_sample_o,
    output logic                  ws_sample_vld_o,
    output logic                  ws_busy_o,
    output logic                  ws_done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]   start_q, start_d;
    logic [ADDR_WIDTH-1:0]   end_q, end_d;
    logic                    mode_q, mode_d;
    logic                    wc_prev_q;
    logic                    rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic                    vld_q, done_q;
    logic                    tick;

    assign tick = ws_wc_clk_i & ~wc_prev_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        start_d  = start_q;
        end_d    = end_q;
        mode_d   = mode_q;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        last_d   = 1'b0;
        sample_d = rd_q ? ws_mem_data_i : sample_q;

        unique case (state_q)
            StIdle: begin
                if (ws_en_i) begin
                    start_d = ws_start_addr_i;
                    end_d   = ws_end_addr_i;
                    mode_d  = ws_mode_i;
                    ptr_d   = ws_start_addr_i;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!ws_en_i) begin
                    state_d = StIdle;
                end else if (tick) begin
                    rd_d   = 1'b1;
                    addr_d = ptr_q;
                    if (ptr_q != end_q) begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end else if (!mode_q) begin
                        ptr_d = start_q;
                    end else begin
                        // Final read of a one-shot; done follows with its sample.
                        last_d  = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (!ws_en_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            start_q   <= '0;
            end_q     <= '0;
            mode_q    <= 1'b0;
            wc_prev_q <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            sample_q  <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            end_q     <= end_d;
            mode_q    <= mode_d;
            wc_prev_q <= ws_wc_clk_i;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            sample_q  <= sample_d;
            vld_q     <= rd_q;
            done_q    <= rd_q & last_q;
        end
    end

    assign ws_mem_rd_o     = rd_q;
    assign ws_mem_addr_o   = addr_q;
    assign ws_sample_o     = sample_q;
    assign ws_sample_vld_o = vld_q;
    assign ws_busy_o       = (state_q == StRun);
    assign ws_done_o       = done_q;

endmodule

// File: tb/tb_waveform_sequencer.sv
// Self-checking bench for waveform_sequencer: random memory contents and windows, checked against
// an address-window model (start + k mod length) and a read/valid timing record.
module tb_waveform_sequencer;

    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 12;
    localparam int          DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          mode = 1'b0;
    logic          wc = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] sample;
    logic          vld;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            wc_half = 3;
    int            wc_cnt = 0;

    int            rd_addr_q[$];
    int            rd_cyc_q[$];
    int            vld_data_q[$];
    int            vld_cyc_q[$];
    int            done_cyc_q[$];

    waveform_sequencer #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst_n),
        .ws_en_i        (en),
        .ws_mode_i      (mode),
        .ws_wc_clk_i    (wc),
        .ws_start_addr_i(start_addr),
        .ws_end_addr_i  (end_addr),
        .ws_mem_rd_o    (mem_rd),
        .ws_mem_addr_o  (mem_addr),
        .ws_mem_data_i  (mem_data),
        .ws_sample_o    (sample),
        .ws_sample_vld_o(vld),
        .ws_busy_o      (busy),
        .ws_done_o      (done)
    );

    // Memory returns the word at the held read address, so it is valid through the following cycle.
    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                rd_addr_q.push_back(int'(mem_addr));
                rd_cyc_q.push_back(cyc);
            end
            if (vld) begin
                vld_data_q.push_back(int'(sample));
                vld_cyc_q.push_back(cyc);
            end
            if (done) done_cyc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (wc_cnt >= wc_half - 1) begin
            wc     = ~wc;
            wc_cnt = 0;
        end else begin
            wc_cnt++;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        vld_data_q.delete();
        vld_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic stop_and_drain();
        en = 1'b0;
        repeat (5) step();
        clear_q();
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 2000 && rd_addr_q.size() < n; i++) step();
    endtask

    // Enable with the given window and check the first n reads against the window model.
    task automatic run_window(input string name, input int s, input int e, input int m,
                              input int half, input int n);
        int len;
        int exp;
        start_addr = s[AW-1:0];
        end_addr   = e[AW-1:0];
        mode       = m[0];
        wc_half    = half;
        clear_q();
        en = 1'b1;
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy: got %0b expected 1", name, busy);
        end
        wait_reads(n);
        repeat (3) step();
        len = ((e - s + DEPTH) % DEPTH) + 1;
        checks++;
        if (rd_addr_q.size() < n || vld_cyc_q.size() < n) begin
            failures++;
            $display("FAIL %s_count: got reads=%0d valids=%0d expected at least %0d",
                     name, rd_addr_q.size(), vld_cyc_q.size(), n);
        end else begin
            for (int k = 0; k < n; k++) begin
                exp = (s + (k % len)) % DEPTH;
                checks++;
                if (rd_addr_q[k] !== exp) begin
                    failures++;
                    $display("FAIL %s_addr[%0d]: got %0d expected %0d", name, k, rd_addr_q[k], exp);
                end
                checks++;
                if (vld_cyc_q[k] !== rd_cyc_q[k] + 1) begin
                    failures++;
                    $display("FAIL %s_latency[%0d]: got vld cycle %0d expected %0d",
                             name, k, vld_cyc_q[k], rd_cyc_q[k] + 1);
                end
                checks++;
                if (vld_data_q[k] !== int'(mem[exp])) begin
                    failures++;
                    $display("FAIL %s_data[%0d]: got %0h expected %0h",
                             name, k, vld_data_q[k], mem[exp]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if ({busy, mem_rd, vld, done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, mem_rd, vld, done});
        end
        checks++;
        if (mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr: got %0d expected 0", mem_addr);
        end
        checks++;
        if (sample !== '0) begin
            failures++;
            $display("FAIL reset_sample: got %0h expected 0", sample);
        end
    endtask

    task automatic test_continuous();
        run_window("cont", 4, 6, 0, 3, 6);
        stop_and_drain();
    endtask

    task automatic test_oneshot();
        run_window("oneshot", 10, 12, 1, 3, 3);
        checks++;
        if (done_cyc_q.size() != 1 || vld_cyc_q.size() < 3) begin
            failures++;
            $display("FAIL oneshot_done_count: got %0d expected 1", done_cyc_q.size());
        end else if (done_cyc_q[0] !== vld_cyc_q[2]) begin
            failures++;
            $display("FAIL oneshot_done_cycle: got %0d expected %0d", done_cyc_q[0], vld_cyc_q[2]);
        end
        repeat (120) step();
        checks++;
        if (rd_addr_q.size() != 3) begin
            failures++;
            $display("FAIL oneshot_hold: got %0d reads expected 3", rd_addr_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_busy_done: got %0b expected 0", busy);
        end
        stop_and_drain();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_busy_idle: got %0b expected 0", busy);
        end
        run_window("oneshot_rearm", 10, 12, 1, 2, 3);
        stop_and_drain();
    endtask

    task automatic test_wrap();
        run_window("wrap", 1022, 1, 0, 2, 5);
        stop_and_drain();
    endtask

    task automatic test_en_drop();
        start_addr = 10'd20;
        end_addr   = 10'd27;
        mode       = 1'b0;
        wc_half    = 3;
        clear_q();
        en = 1'b1;
        wait_reads(1);
        en = 1'b0;
        repeat (20) step();
        checks++;
        if (rd_addr_q.size() != 1) begin
            failures++;
            $display("FAIL endrop_reads: got %0d expected 1", rd_addr_q.size());
        end
        checks++;
        if (vld_cyc_q.size() != 1 || rd_cyc_q.size() < 1) begin
            failures++;
            $display("FAIL endrop_vld_count: got %0d expected 1", vld_cyc_q.size());
        end else if (vld_cyc_q[0] !== rd_cyc_q[0] + 1) begin
            failures++;
            $display("FAIL endrop_vld_cycle: got %0d expected %0d", vld_cyc_q[0], rd_cyc_q[0] + 1);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL endrop_busy: got %0b expected 0", busy);
        end
        run_window("endrop_restart", 20, 27, 0, 3, 2);
        stop_and_drain();
    endtask

    task automatic test_async_reset();
        run_window("prereset", 100, 105, 0, 2, 3);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, mem_rd, vld, done} !== 4'b0) begin
            failures++;
            $display("FAIL areset_flags: got %b expected 0000", {busy, mem_rd, vld, done});
        end
        checks++;
        if (mem_addr !== '0 || sample !== '0) begin
            failures++;
            $display("FAIL areset_data: got addr=%0d sample=%0h expected 0 0", mem_addr, sample);
        end
        clear_q();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        wait_reads(1);
        checks++;
        if (rd_addr_q.size() < 1) begin
            failures++;
            $display("FAIL areset_restart: got no read expected address 100");
        end else if (rd_addr_q[0] !== 100) begin
            failures++;
            $display("FAIL areset_restart: got %0d expected 100", rd_addr_q[0]);
        end
        stop_and_drain();
    endtask

    task automatic test_cfg_change();
        int exp;
        start_addr = 10'd4;
        end_addr   = 10'd6;
        mode       = 1'b0;
        wc_half    = 2;
        clear_q();
        en = 1'b1;
        wait_reads(1);
        start_addr = 10'd0;
        end_addr   = 10'd8;
        mode       = 1'b1;
        wait_reads(7);
        checks++;
        if (rd_addr_q.size() < 7) begin
            failures++;
            $display("FAIL cfg_count: got %0d expected 7", rd_addr_q.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                exp = 4 + (k % 3);
                checks++;
                if (rd_addr_q[k] !== exp) begin
                    failures++;
                    $display("FAIL cfg_addr[%0d]: got %0d expected %0d", k, rd_addr_q[k], exp);
                end
            end
        end
        stop_and_drain();
        run_window("cfg_relatch", 4, 8, 0, 2, 6);
        stop_and_drain();
    endtask

    task automatic test_random();
        int s, e, m, half, len;
        for (int it = 0; it < 6; it++) begin
            s    = $urandom_range(0, DEPTH - 1);
            e    = (s + $urandom_range(0, 5)) % DEPTH;
            m    = $urandom_range(0, 1);
            half = $urandom_range(1, 4);
            len  = ((e - s + DEPTH) % DEPTH) + 1;
            run_window("rand", s, e, m, half, (m != 0) ? len : len + 3);
            if (m != 0) begin
                checks++;
                if (done_cyc_q.size() != 1 || vld_cyc_q.size() < len) begin
                    failures++;
                    $display("FAIL rand_done_count: got %0d expected 1", done_cyc_q.size());
                end else if (done_cyc_q[0] !== vld_cyc_q[len-1]) begin
                    failures++;
                    $display("FAIL rand_done_cycle: got %0d expected %0d",
                             done_cyc_q[0], vld_cyc_q[len-1]);
                end
            end
            stop_and_drain();
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom_range(1, (1 << DW) - 1));
        test_reset();
        test_continuous();
        test_oneshot();
        test_wrap();
        test_en_drop();
        test_async_reset();
        test_cfg_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
